imem_loader: RTL and testbench

//  Synthesizable program loader for the MIPS core: receives a byte stream (length header + program words),

---
 rtl/imem_loader_pkg.sv | 21 ++
 rtl/imem_loader_if.sv | 33 +++
 rtl/imem_loader_byte_packer.sv | 39 +++
 rtl/imem_loader.sv | 132 +++++++++++++
 tb/tb_imem_loader.sv | 345 ++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/imem_loader_pkg.sv
// Shared definitions for the instruction-memory program loader:
// FSM state encoding and stream framing constants.
package imem_loader_pkg;

    typedef enum logic [2:0] {
        StHdr0,
        StHdr1,
        StData,
        StDone,
        StErr
    } loader_state_e;

    localparam int unsigned HDR_BYTES      = 2;
    localparam int unsigned BYTES_PER_WORD = 4;

    // Total stream length in bytes for a program of n_words words.
    function automatic int unsigned stream_bytes(input int unsigned n_words);
        return HDR_BYTES + BYTES_PER_WORD * n_words;
    endfunction

endpackage

// File: rtl/imem_loader_if.sv
// Byte-stream input and imem write port of the program loader.
// master = byte source / imem side, slave = the loader.
interface imem_loader_if #(
    parameter int unsigned ADDR_W = 8,
    parameter int unsigned WORD_W = 32
) ();

    logic              in_valid;
    logic [7:0]        in_data;
    logic              in_ready;
    logic              imem_we;
    logic [ADDR_W-1:0] imem_waddr;
    logic [WORD_W-1:0] imem_wdata;

    modport master (
        output in_valid,
        output in_data,
        input  in_ready,
        input  imem_we,
        input  imem_waddr,
        input  imem_wdata
    );

    modport slave (
        input  in_valid,
        input  in_data,
        output in_ready,
        output imem_we,
        output imem_waddr,
        output imem_wdata
    );

endinterface

// File: rtl/imem_loader_byte_packer.sv
// Assembles little-endian bytes into words; word_valid pulses together with
// the last byte so the caller can register the completed word on that edge.
module imem_loader_byte_packer
    import imem_loader_pkg::*;
#(
    parameter int unsigned WORD_W = 32
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              clear,
    input  logic              byte_valid,
    input  logic [7:0]        byte_data,
    output logic              word_valid,
    output logic [WORD_W-1:0] word
);

    localparam int unsigned IdxW = $clog2(BYTES_PER_WORD);

    logic [IdxW-1:0]   idx_q;
    logic [WORD_W-9:0] part_q;

    assign word_valid = byte_valid && (idx_q == IdxW'(BYTES_PER_WORD - 1));
    assign word       = {byte_data, part_q};

    // Shift right so the first byte of a word ends up in bits [7:0].
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            idx_q  <= '0;
            part_q <= '0;
        end else if (clear) begin
            idx_q  <= '0;
            part_q <= '0;
        end else if (byte_valid) begin
            idx_q  <= idx_q + IdxW'(1);
            part_q <= {byte_data, part_q[WORD_W-9:8]};
        end
    end

endmodule

// File: rtl/imem_loader.sv
// Program loader: parses a length-prefixed byte stream, writes the words into
// instruction memory from address 0 and holds the core in reset until done.
module imem_loader
    import imem_loader_pkg::*;
#(
    parameter int unsigned ADDR_W = 8,
    parameter int unsigned WORD_W = 32
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          reload,
    imem_loader_if.slave  bus,
    output logic          cpu_reset,
    output logic          done,
    output logic          error
);

    localparam logic [16:0] Capacity = 17'(1) << ADDR_W;

    loader_state_e     state_q;
    logic [15:0]       n_q;
    logic [ADDR_W:0]   wcnt_q;
    logic              in_ready_q;
    logic              we_q;
    logic [ADDR_W-1:0] waddr_q;
    logic [WORD_W-1:0] wdata_q;
    logic              cpu_reset_q;
    logic              done_q;
    logic              error_q;

    logic              xfer;
    logic              word_valid;
    logic [WORD_W-1:0] word;
    logic [15:0]       hdr_n;
    logic [16:0]       wcnt_inc;
    logic              finished;

    assign xfer     = bus.in_valid && in_ready_q;
    assign hdr_n    = {bus.in_data, n_q[7:0]};
    assign wcnt_inc = 17'(wcnt_q) + 17'd1;
    assign finished = (state_q == StDone || state_q == StErr) && !reload;

    imem_loader_byte_packer #(
        .WORD_W (WORD_W)
    ) u_packer (
        .clk        (clk),
        .reset      (reset),
        .clear      (state_q != StData),
        .byte_valid (xfer && state_q == StData),
        .byte_data  (bus.in_data),
        .word_valid (word_valid),
        .word       (word)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= StHdr0;
            n_q         <= '0;
            wcnt_q      <= '0;
            in_ready_q  <= 1'b0;
            we_q        <= 1'b0;
            waddr_q     <= '0;
            wdata_q     <= '0;
            cpu_reset_q <= 1'b1;
            done_q      <= 1'b0;
            error_q     <= 1'b0;
        end else begin
            we_q <= 1'b0;
            unique case (state_q)
                StHdr0: begin
                    in_ready_q <= 1'b1;
                    if (xfer) begin
                        n_q[7:0] <= bus.in_data;
                        state_q  <= StHdr1;
                    end
                end
                StHdr1: begin
                    if (xfer) begin
                        n_q[15:8] <= bus.in_data;
                        wcnt_q    <= '0;
                        if (hdr_n == 16'd0) begin
                            state_q    <= StDone;
                            in_ready_q <= 1'b0;
                        end else if ({1'b0, hdr_n} > Capacity) begin
                            state_q    <= StErr;
                            in_ready_q <= 1'b0;
                        end else begin
                            state_q <= StData;
                        end
                    end
                end
                StData: begin
                    if (word_valid) begin
                        we_q    <= 1'b1;
                        waddr_q <= wcnt_q[ADDR_W-1:0];
                        wdata_q <= word;
                        wcnt_q  <= wcnt_q + {{ADDR_W{1'b0}}, 1'b1};
                        if (wcnt_inc == {1'b0, n_q}) begin
                            state_q    <= StDone;
                            in_ready_q <= 1'b0;
                        end
                    end
                end
                StDone, StErr: begin
                    if (reload) begin
                        state_q    <= StHdr0;
                        in_ready_q <= 1'b1;
                        n_q        <= '0;
                        wcnt_q     <= '0;
                    end
                end
                default: begin
                    state_q    <= StHdr0;
                    in_ready_q <= 1'b0;
                end
            endcase
            // Status lags the state by one cycle so cpu_reset drops after the last write.
            done_q      <= finished && state_q == StDone;
            error_q     <= finished && state_q == StErr;
            cpu_reset_q <= !(finished && state_q == StDone);
        end
    end

    assign bus.in_ready   = in_ready_q;
    assign bus.imem_we    = we_q;
    assign bus.imem_waddr = waddr_q;
    assign bus.imem_wdata = wdata_q;
    assign cpu_reset      = cpu_reset_q;
    assign done           = done_q;
    assign error          = error_q;

endmodule

// File: tb/tb_imem_loader.sv
// Scoreboard bench for imem_loader: expected writes are queued as bytes are
// driven and checked against every imem_we pulse.
module tb_imem_loader;
    import imem_loader_pkg::*;

    typedef struct {
        logic [7:0]  addr;
        logic [31:0] data;
    } wr_t;

    logic clk = 1'b0;
    logic reset;
    logic reload;
    logic cpu_reset;
    logic done;
    logic error;

    int n_cmp  = 0;
    int n_err  = 0;
    int wr_cnt = 0;
    wr_t exp_q[$];

    imem_loader_if #(.ADDR_W(8), .WORD_W(32)) bus ();

    imem_loader #(
        .ADDR_W (8),
        .WORD_W (32)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .reload    (reload),
        .bus       (bus),
        .cpu_reset (cpu_reset),
        .done      (done),
        .error     (error)
    );

    always #5 clk = ~clk;

    // Write monitor and DONE-state ready check.
    always @(negedge clk) begin
        if (bus.imem_we === 1'b1) begin
            wr_t e;
            wr_cnt++;
            n_cmp++;
            if (exp_q.size() == 0) begin
                n_err++;
                $display("FAIL unexpected_write: addr=%0d data=%h, none required",
                         bus.imem_waddr, bus.imem_wdata);
            end else begin
                e = exp_q.pop_front();
                if (bus.imem_waddr !== e.addr || bus.imem_wdata !== e.data) begin
                    n_err++;
                    $display("FAIL write: got addr=%0d data=%h, required addr=%0d data=%h",
                             bus.imem_waddr, bus.imem_wdata, e.addr, e.data);
                end
            end
        end
        if (done === 1'b1) begin
            n_cmp++;
            if (bus.in_ready !== 1'b0) begin
                n_err++;
                $display("FAIL ready_in_done: in_ready=%b, required 0", bus.in_ready);
            end
        end
    end

    // Drives one byte and returns at the negedge before the transferring posedge.
    task automatic send_byte(input logic [7:0] b, input bit gaps);
        int guard = 0;
        if (gaps) begin
            repeat ($urandom_range(0, 3)) begin
                @(negedge clk);
                bus.in_valid = 1'b0;
            end
        end
        @(negedge clk);
        bus.in_valid = 1'b1;
        bus.in_data  = b;
        while (bus.in_ready !== 1'b1 && guard < 200) begin
            @(negedge clk);
            guard++;
        end
        if (guard >= 200) begin
            n_cmp++;
            n_err++;
            $display("FAIL byte_accept_timeout: in_ready=%b, required 1", bus.in_ready);
        end
    endtask

    task automatic send_header(input logic [15:0] n, input bit gaps);
        send_byte(n[7:0], gaps);
        send_byte(n[15:8], gaps);
    endtask

    task automatic send_word(input logic [7:0] addr, input logic [31:0] w, input bit gaps);
        wr_t e;
        e.addr = addr;
        e.data = w;
        exp_q.push_back(e);
        for (int i = 0; i < 4; i++) send_byte(w[8*i +: 8], gaps);
    endtask

    task automatic idle();
        @(negedge clk);
        bus.in_valid = 1'b0;
    endtask

    task automatic wait_done(input int unsigned n_words);
        int unsigned budget = stream_bytes(n_words) * 4 + 20;
        int unsigned g = 0;
        while (done !== 1'b1 && g < budget) begin
            @(negedge clk);
            g++;
        end
        if (done !== 1'b1) begin
            n_cmp++;
            n_err++;
            $display("FAIL done_timeout: done=%b, required 1", done);
        end
    endtask

    task automatic do_reload();
        @(negedge clk);
        reload = 1'b1;
        @(negedge clk);
        reload = 1'b0;
        n_cmp++;
        if (done !== 1'b0 || error !== 1'b0 || cpu_reset !== 1'b1) begin
            n_err++;
            $display("FAIL reload: done=%b error=%b cpu_reset=%b, required 0 0 1",
                     done, error, cpu_reset);
        end
    endtask

    task automatic test_reset();
        reset        = 1'b1;
        reload       = 1'b0;
        bus.in_valid = 1'b0;
        bus.in_data  = 8'h00;
        #2 reset = 1'b0;
        #1;
        n_cmp++;
        if (bus.in_ready !== 1'b0 || bus.imem_we !== 1'b0) begin
            n_err++;
            $display("FAIL reset_handshake: in_ready=%b imem_we=%b, required 0 0",
                     bus.in_ready, bus.imem_we);
        end
        n_cmp++;
        if (bus.imem_waddr !== 8'd0 || bus.imem_wdata !== 32'd0) begin
            n_err++;
            $display("FAIL reset_port: waddr=%h wdata=%h, required 0 0",
                     bus.imem_waddr, bus.imem_wdata);
        end
        n_cmp++;
        if (cpu_reset !== 1'b1 || done !== 1'b0 || error !== 1'b0) begin
            n_err++;
            $display("FAIL reset_status: cpu_reset=%b done=%b error=%b, required 1 0 0",
                     cpu_reset, done, error);
        end
        repeat (2) @(negedge clk);
        n_cmp++;
        if (bus.in_ready !== 1'b0) begin
            n_err++;
            $display("FAIL reset_held_ready: in_ready=%b, required 0", bus.in_ready);
        end
        reset = 1'b1;
    endtask

    task automatic test_basic();
        int w0 = wr_cnt;
        send_header(16'd3, 1'b0);
        send_word(8'd0, 32'h2008_0005, 1'b0);
        send_word(8'd1, 32'h2009_000A, 1'b0);
        send_word(8'd2, 32'h0109_5020, 1'b0);
        idle();
        n_cmp++;
        if (bus.imem_we !== 1'b1 || cpu_reset !== 1'b1 || done !== 1'b0) begin
            n_err++;
            $display("FAIL basic_last_pulse: we=%b cpu_reset=%b done=%b, required 1 1 0",
                     bus.imem_we, cpu_reset, done);
        end
        @(negedge clk);
        n_cmp++;
        if (done !== 1'b1 || cpu_reset !== 1'b0 || bus.imem_we !== 1'b0) begin
            n_err++;
            $display("FAIL basic_release: done=%b cpu_reset=%b we=%b, required 1 0 0",
                     done, cpu_reset, bus.imem_we);
        end
        n_cmp++;
        if (wr_cnt - w0 != 3 || exp_q.size() != 0) begin
            n_err++;
            $display("FAIL basic_count: writes=%0d pending=%0d, required 3 0",
                     wr_cnt - w0, exp_q.size());
        end
    endtask

    task automatic test_zero_words();
        int w0;
        do_reload();
        w0 = wr_cnt;
        send_header(16'd0, 1'b0);
        idle();
        n_cmp++;
        if (done !== 1'b0 || bus.in_ready !== 1'b0) begin
            n_err++;
            $display("FAIL zero_first: done=%b in_ready=%b, required 0 0", done, bus.in_ready);
        end
        @(negedge clk);
        n_cmp++;
        if (done !== 1'b1 || cpu_reset !== 1'b0 || wr_cnt != w0) begin
            n_err++;
            $display("FAIL zero_done: done=%b cpu_reset=%b writes=%0d, required 1 0 0",
                     done, cpu_reset, wr_cnt - w0);
        end
    endtask

    task automatic test_overflow();
        int w0;
        do_reload();
        w0 = wr_cnt;
        send_header(16'd257, 1'b0);
        idle();
        @(negedge clk);
        n_cmp++;
        if (error !== 1'b1 || bus.in_ready !== 1'b0 || cpu_reset !== 1'b1 || done !== 1'b0) begin
            n_err++;
            $display("FAIL overflow: error=%b in_ready=%b cpu_reset=%b done=%b, required 1 0 1 0",
                     error, bus.in_ready, cpu_reset, done);
        end
        bus.in_valid = 1'b1;
        bus.in_data  = 8'h5A;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            n_cmp++;
            if (bus.in_ready !== 1'b0 || error !== 1'b1) begin
                n_err++;
                $display("FAIL err_hold: in_ready=%b error=%b, required 0 1", bus.in_ready, error);
            end
        end
        bus.in_valid = 1'b0;
        n_cmp++;
        if (wr_cnt != w0) begin
            n_err++;
            $display("FAIL err_writes: writes=%0d, required 0", wr_cnt - w0);
        end
        do_reload();
        send_header(16'd1, 1'b0);
        send_word(8'd0, 32'hDEAD_BEEF, 1'b0);
        idle();
        wait_done(1);
        n_cmp++;
        if (done !== 1'b1 || error !== 1'b0 || exp_q.size() != 0) begin
            n_err++;
            $display("FAIL err_recover: done=%b error=%b pending=%0d, required 1 0 0",
                     done, error, exp_q.size());
        end
    endtask

    task automatic test_gaps();
        int w0;
        do_reload();
        w0 = wr_cnt;
        send_header(16'd2, 1'b1);
        send_word(8'd0, 32'h2008_0005, 1'b1);
        send_word(8'd1, 32'h2009_000A, 1'b1);
        idle();
        wait_done(2);
        n_cmp++;
        if (done !== 1'b1 || wr_cnt - w0 != 2 || exp_q.size() != 0) begin
            n_err++;
            $display("FAIL gaps: done=%b writes=%0d pending=%0d, required 1 2 0",
                     done, wr_cnt - w0, exp_q.size());
        end
    endtask

    task automatic test_abort();
        int w0;
        do_reload();
        w0 = wr_cnt;
        send_header(16'd4, 1'b0);
        send_word(8'd0, 32'h1111_2222, 1'b0);
        send_byte(8'hAA, 1'b0);
        send_byte(8'hBB, 1'b0);
        @(negedge clk);
        bus.in_valid = 1'b0;
        reset        = 1'b0;
        #1;
        n_cmp++;
        if (cpu_reset !== 1'b1 || done !== 1'b0 || bus.in_ready !== 1'b0 || bus.imem_we !== 1'b0)
        begin
            n_err++;
            $display("FAIL abort_reset: cpu_reset=%b done=%b in_ready=%b we=%b, required 1 0 0 0",
                     cpu_reset, done, bus.in_ready, bus.imem_we);
        end
        @(negedge clk);
        reset = 1'b1;
        send_header(16'd1, 1'b0);
        send_word(8'd0, 32'hCAFE_F00D, 1'b0);
        idle();
        wait_done(1);
        n_cmp++;
        if (done !== 1'b1 || wr_cnt - w0 != 2 || exp_q.size() != 0) begin
            n_err++;
            $display("FAIL abort_reload: done=%b writes=%0d pending=%0d, required 1 2 0",
                     done, wr_cnt - w0, exp_q.size());
        end
    endtask

    task automatic test_full_capacity();
        int w0;
        do_reload();
        w0 = wr_cnt;
        send_header(16'd256, 1'b0);
        for (int i = 0; i < 256; i++) send_word(8'(i), $urandom, 1'b0);
        idle();
        wait_done(256);
        n_cmp++;
        if (done !== 1'b1 || error !== 1'b0 || wr_cnt - w0 != 256 || exp_q.size() != 0) begin
            n_err++;
            $display("FAIL full: done=%b error=%b writes=%0d pending=%0d, required 1 0 256 0",
                     done, error, wr_cnt - w0, exp_q.size());
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_basic();
        test_zero_words();
        test_overflow();
        test_gaps();
        test_abort();
        test_full_capacity();
        repeat (3) @(negedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
